// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit owns a slot of REFRESH_DIV clock cycles; the first GUARD cycles
// of every slot keep all anodes off to suppress ghosting while segments
// settle. The four glyph codes and the blank mask are captured once per scan
// frame (on the wrap from digit D back to digit A) so a message never tears
// mid-frame.
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_a..i_d      4-bit glyph codes, i_a leftmost (o_an[3]) .. i_d rightmost
//   i_blank       1 = digit dark; [3]=A, [2]=B, [1]=C, [0]=D
//   o_an          anode enables, active-low, at most one low
//   o_seg         segments {g,f,e,d,c,b,a}, active-low
//   o_dp          decimal point, active-low, held off
//   o_frame_tick  one-cycle pulse on the cycle a new snapshot is taken
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [3:0] i_c,
  input  logic [3:0] i_d,
  input  logic [3:0] i_blank,
  output logic [3:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic       o_frame_tick
);

  localparam int             CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  GUARD_C  = CW'(GUARD);

  // Glyph code to active-low {g..a} segment pattern.
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0101111; // 'r'
      4'hB:    pat = 7'b1000010; // 'G'
      4'hC:    pat = 7'b0010001; // 'y'
      4'hD:    pat = 7'b0100001; // 'd'
      4'hE:    pat = 7'b0100011; // 'o'
      4'hF:    pat = 7'b0111111; // '-'
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Slot index to active-low one-hot anode; slot 0 (digit A) is an[3].
  function automatic logic [3:0] f_anode(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = 4'b0111;
      2'd1:    an = 4'b1011;
      2'd2:    an = 4'b1101;
      2'd3:    an = 4'b1110;
      default: an = 4'b1111;
    endcase
    return an;
  endfunction

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_snap_a;
  logic [3:0]    r_snap_b;
  logic [3:0]    r_snap_c;
  logic [3:0]    r_snap_d;
  logic [3:0]    r_snap_blank;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame_tick;

  logic          w_term;
  logic          w_wrap;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic          w_tick_nxt;
  logic [3:0]    w_code_sel;
  logic          w_blank_sel;
  logic [3:0]    w_an_nxt;

  // Divider next state and the wrap that triggers a snapshot.
  always_comb begin
    w_term    = (r_cnt == CNT_LAST);
    w_wrap    = w_term && (r_idx == 2'd3);
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    if (w_term) begin
      w_cnt_nxt = '0;
      w_idx_nxt = r_idx + 2'd1;
    end else begin
      w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
      w_idx_nxt = r_idx;
    end
    // Registered tick lines up with the cycle whose state is the wrap.
    w_tick_nxt = (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == 2'd3);
  end

  // Select the snapshot code and blank bit for the current slot.
  always_comb begin
    w_code_sel  = 4'h0;
    w_blank_sel = 1'b1;
    case (r_idx)
      2'd0: begin
        w_code_sel  = r_snap_a;
        w_blank_sel = r_snap_blank[3];
      end
      2'd1: begin
        w_code_sel  = r_snap_b;
        w_blank_sel = r_snap_blank[2];
      end
      2'd2: begin
        w_code_sel  = r_snap_c;
        w_blank_sel = r_snap_blank[1];
      end
      2'd3: begin
        w_code_sel  = r_snap_d;
        w_blank_sel = r_snap_blank[0];
      end
      default: begin
        w_code_sel  = 4'h0;
        w_blank_sel = 1'b1;
      end
    endcase
  end

  // Anode enable: dark during the guard interval or for a blanked digit.
  always_comb begin
    w_an_nxt = 4'b1111;
    if (r_cnt < GUARD_C) begin
      w_an_nxt = 4'b1111;
    end else if (w_blank_sel) begin
      w_an_nxt = 4'b1111;
    end else begin
      w_an_nxt = f_anode(r_idx);
    end
  end

  // Divider, slot index, frame snapshot and registered display outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_snap_a     <= 4'h0;
      r_snap_b     <= 4'h0;
      r_snap_c     <= 4'h0;
      r_snap_d     <= 4'h0;
      r_snap_blank <= 4'b1111;
      r_an         <= 4'b1111;
      r_seg        <= 7'b1111111;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_an         <= w_an_nxt;
      // Segments follow the slot even in guard; anodes gate visibility.
      r_seg        <= f_decode(w_code_sel);
      r_frame_tick <= w_tick_nxt;
      if (w_wrap) begin
        r_snap_a     <= i_a;
        r_snap_b     <= i_b;
        r_snap_c     <= i_c;
        r_snap_d     <= i_d;
        r_snap_blank <= i_blank;
      end else begin
        r_snap_a     <= r_snap_a;
        r_snap_b     <= r_snap_b;
        r_snap_c     <= r_snap_c;
        r_snap_d     <= r_snap_d;
        r_snap_blank <= r_snap_blank;
      end
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp         = 1'b1;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with REFRESH_DIV=8, GUARD=2.
// Reference model works from an absolute cycle count since reset: slot and
// offset are derived arithmetically, glyphs come from a lookup table.
module tb_seg_scan_driver;

  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       reset;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] c_in;
  logic [3:0] d_in;
  logic [3:0] blank_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  seg_scan_driver #(
    .REFRESH_DIV(DIV),
    .GUARD      (GRD)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_a         (a_in),
    .i_b         (b_in),
    .i_c         (c_in),
    .i_d         (d_in),
    .i_blank     (blank_in),
    .o_an        (an),
    .o_seg       (seg),
    .o_dp        (dp),
    .o_frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h2F, 7'h42, 7'h11, 7'h21, 7'h23, 7'h3F
  };

  int         n_vec;
  int         n_err;
  int         cyc;
  int         last_tick;
  int         m_t;
  logic [3:0] m_code [4];
  logic [3:0] m_blank;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs now driven,
  // then check the DUT at the following negedge.
  task automatic tick();
    int cnt;
    int idx;
    if (reset) begin
      m_t       = 0;
      for (int k = 0; k < 4; k++) m_code[k] = 4'h0;
      m_blank   = 4'b1111;
      e_an      = 4'b1111;
      e_seg     = 7'b1111111;
      e_tick    = 1'b0;
      last_tick = -1;
    end else begin
      cnt   = m_t % DIV;
      idx   = (m_t / DIV) % 4;
      if (cnt < GRD || m_blank[3 - idx]) e_an = 4'b1111;
      else                               e_an = ~(4'b1000 >> idx);
      e_seg = glyph[m_code[idx]];
      if (cnt == DIV - 1 && idx == 3) begin
        m_code[0] = a_in;
        m_code[1] = b_in;
        m_code[2] = c_in;
        m_code[3] = d_in;
        m_blank   = blank_in;
      end
      m_t    = m_t + 1;
      e_tick = ((m_t % FRAME) == FRAME - 1);
    end
    @(negedge clk);
    cyc++;
    chk("an", {28'h0, an}, {28'h0, e_an});
    chk("seg", {25'h0, seg}, {25'h0, e_seg});
    chk("dp", {31'h0, dp}, 32'h1);
    chk("frame_tick", {31'h0, frame_tick}, {31'h0, e_tick});
    chk("one_anode", {31'h0, ($countones(~an) <= 1)}, 32'h1);
    if (frame_tick === 1'b1) begin
      if (last_tick >= 0) chk("tick_period", cyc - last_tick, FRAME);
      last_tick = cyc;
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    last_tick = -1;
    m_t       = 0;
    m_blank   = 4'b1111;
    for (int k = 0; k < 4; k++) m_code[k] = 4'h0;
    e_an      = 4'b1111;
    e_seg     = 7'b1111111;
    e_tick    = 1'b0;
    a_in      = 4'h0;
    b_in      = 4'h0;
    c_in      = 4'h0;
    d_in      = 4'h0;
    blank_in  = 4'b0000;

    // Reset held for 3 cycles.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Message "0r4y" with A blanked; first frame after reset stays dark.
    a_in     = 4'h0;
    b_in     = 4'hA;
    c_in     = 4'h4;
    d_in     = 4'hC;
    blank_in = 4'b1000;
    repeat (FRAME) tick();
    repeat (2 * FRAME) tick();

    // Change C mid-frame during the B slot; must not show until next wrap.
    repeat (DIV + 2) tick();
    c_in = 4'hB;
    repeat (FRAME - DIV - 2 + FRAME) tick();

    // Sweep all glyph codes on D, only D visible.
    blank_in = 4'b1110;
    for (int code = 0; code < 16; code++) begin
      d_in = 4'(code);
      repeat (FRAME) tick();
    end

    // Reset for one cycle while idx=2, cnt=5.
    blank_in = 4'b0000;
    for (int k = 0; k < FRAME && (m_t % FRAME) != (2 * DIV + 5); k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (FRAME + 8) tick();

    // Random inputs changing every cycle over 10 frames.
    repeat (10 * FRAME) begin
      a_in     = 4'($urandom_range(15, 0));
      b_in     = 4'($urandom_range(15, 0));
      c_in     = 4'($urandom_range(15, 0));
      d_in     = 4'($urandom_range(15, 0));
      blank_in = 4'($urandom_range(15, 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
